// File: rtl/cpu_controller_if.sv
// Bundle of the sequencer's datapath-facing signals: opcode/flag/ready in, strobes and debug phase out.
// The slave side is the controller; the master side is the datapath or bench that drives opcode/zero/mem_rdy.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rdy;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic       inc_pc;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    output opcode, zero, mem_rdy,
    input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );

  modport slave (
    input  opcode, zero, mem_rdy,
    output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );
endinterface

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer for the accumulator CPU.
// Only phase and halted are stored; every strobe is a combinational decode of them plus opcode/zero.
module cpu_controller (
  input  logic            clk,
  input  logic            rst_,
  cpu_controller_if.slave bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;
  logic stall;

  assign is_hlt = (bus.opcode == OP_HLT);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign is_alu = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  // Memory-wait only matters in the two phases that actually read memory.
  assign stall = (!bus.mem_rdy && (phase_q == INST_FETCH)) ||
                 (!bus.mem_rdy && (phase_q == OP_FETCH) && (is_alu || is_sto));

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((phase_q == OP_ADDR) && is_hlt) begin
        halted_d = 1'b1;
      end else if (!stall) begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  logic ph_fetch_side, ph_ir_load, ph_op_rd, ph_exec;

  assign ph_fetch_side = (phase_q == INST_ADDR) || (phase_q == INST_FETCH) ||
                         (phase_q == INST_LOAD) || (phase_q == IDLE);
  assign ph_ir_load    = (phase_q == INST_LOAD) || (phase_q == IDLE);
  assign ph_op_rd      = (phase_q == OP_FETCH)  || (phase_q == ALU_OP) || (phase_q == STORE);
  assign ph_exec       = (phase_q == ALU_OP)    || (phase_q == STORE);

  // A halted CPU keeps phase at OP_ADDR but must not pulse anything except halt.
  assign bus.sel    = !halted_q && ph_fetch_side;
  assign bus.rd     = !halted_q && ((ph_fetch_side && (phase_q != INST_ADDR)) ||
                                    (ph_op_rd && is_alu));
  assign bus.ld_ir  = !halted_q && ph_ir_load;
  assign bus.inc_pc = !halted_q && (((phase_q == OP_ADDR) && !is_hlt) ||
                                    ((phase_q == ALU_OP) && is_skz && bus.zero));
  assign bus.ld_pc  = !halted_q && ph_exec && is_jmp;
  assign bus.data_e = !halted_q && ph_exec && is_sto;
  assign bus.ld_ac  = !halted_q && (phase_q == STORE) && is_alu;
  assign bus.wr     = !halted_q && (phase_q == STORE) && is_sto;
  assign bus.halt   = halted_q || ((phase_q == OP_ADDR) && is_hlt);
  assign bus.phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues per-cycle expected phase/strobes,
// a negedge monitor pops and compares them against the DUT.
module tb_cpu_controller;

  logic clk;
  logic rst_;
  int   checks;
  int   failures;
  int   tid;

  // {test id[7:0], phase[2:0], sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt}
  logic [19:0] sb_q[$];

  cpu_controller_if bus();

  cpu_controller u_dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived strobe table per opcode and phase.
  function automatic logic [8:0] exp_vec(input logic [2:0] op, input logic z, input logic [2:0] ph);
    logic [8:0] v;
    v = 9'b000000000;
    case (ph)
      3'd0: v = 9'b100000000;
      3'd1: v = 9'b110000000;
      3'd2,
      3'd3: v = 9'b110100000;
      3'd4: v = (op == 3'd0) ? 9'b000000001 : 9'b000000100;
      default: begin
        case (op)
          3'd2, 3'd3, 3'd4, 3'd5: v = (ph == 3'd7) ? 9'b010010000 : 9'b010000000;
          3'd6: v = (ph == 3'd5) ? 9'b000000000 :
                    (ph == 3'd6) ? 9'b000000010 : 9'b001000010;
          3'd7: v = (ph == 3'd5) ? 9'b000000000 : 9'b000001000;
          3'd1: v = ((ph == 3'd6) && z) ? 9'b000000100 : 9'b000000000;
          default: v = 9'b000000000;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic step(input logic [2:0] ph, input logic rdy, input logic [8:0] v);
    bus.mem_rdy = rdy;
    sb_q.push_back({tid[7:0], ph, v});
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input int nf, input int no, input logic ign);
    bus.opcode = op;
    bus.zero   = z;
    for (int p = 0; p < 8; p++) begin
      if (p == 1) repeat (nf) step(3'd1, 1'b0, exp_vec(op, z, 3'd1));
      if (p == 5) repeat (no) step(3'd5, 1'b0, exp_vec(op, z, 3'd5));
      step(3'(p), (ign && (p != 1)) ? 1'b0 : 1'b1, exp_vec(op, z, 3'(p)));
    end
  endtask

  // Called at posedge+1; reset must be visible before the next clock edge.
  task automatic do_reset();
    rst_ = 1'b0;
    sb_q.push_back({tid[7:0], 3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    sb_q.push_back({tid[7:0], 3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    logic [11:0] got;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      got = {bus.phase, bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
             bus.ld_pc, bus.inc_pc, bus.data_e, bus.halt};
      checks++;
      if (got !== e[11:0]) begin
        failures++;
        $display("FAIL step test=%0d phase got=%0d exp=%0d strobes got=%b exp=%b",
                 e[19:12], got[11:9], e[11:9], got[8:0], e[8:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks      = 0;
    failures    = 0;
    tid         = 0;
    rst_        = 1'b0;
    bus.opcode  = 3'd5;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b1;
    @(posedge clk);
    #1;

    tid = 1; do_reset();
    tid = 2; run_instr(3'd5, 1'b0, 0, 0, 1'b0);          // LDA
    // Reset mid OP_FETCH with no clock edge
    tid = 3;
    for (int p = 0; p < 5; p++) step(3'(p), 1'b1, exp_vec(3'd5, 1'b0, 3'(p)));
    do_reset();
    tid = 4;  run_instr(3'd5, 1'b0, 0, 0, 1'b0);         // full wrap after reset
    tid = 5;  run_instr(3'd6, 1'b0, 0, 0, 1'b0);         // STO
    tid = 6;  run_instr(3'd1, 1'b1, 0, 0, 1'b0);         // SKZ taken
    tid = 7;  run_instr(3'd1, 1'b0, 0, 0, 1'b1);         // SKZ not taken, mem_rdy noise
    tid = 8;  run_instr(3'd7, 1'b1, 0, 0, 1'b1);         // JMP, mem_rdy noise
    tid = 9;  run_instr(3'd5, 1'b0, 3, 0, 1'b0);         // fetch stall x3
    tid = 10; run_instr(3'd2, 1'b0, 0, 2, 1'b0);         // ADD operand stall x2
    tid = 11; run_instr(3'd3, 1'b1, 0, 0, 1'b0);         // AND
    tid = 12; run_instr(3'd4, 1'b0, 1, 0, 1'b0);         // XOR with fetch stall
    tid = 13; run_instr(3'd6, 1'b1, 0, 1, 1'b0);         // STO operand stall

    // HLT: frozen at OP_ADDR, opcode and mem_rdy changes ignored once halted
    tid = 14;
    bus.opcode = 3'd0;
    bus.zero   = 1'b1;
    for (int p = 0; p < 4; p++) step(3'(p), 1'b1, exp_vec(3'd0, 1'b1, 3'(p)));
    for (int i = 0; i < 21; i++) begin
      if (i == 3) bus.opcode = 3'd7;
      step(3'd4, 1'(i % 2), 9'b000000001);
    end
    tid = 15; do_reset();
    tid = 16; run_instr(3'd5, 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: scoreboard entries left got=%0d exp=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
